wr_bus_arbiter: RTL and testbench
=================================

Name: wr_bus_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit write port (addr, data, wen) between N_REQ requesters.
- Each requester presents a write through a valid/ready handshake.
- The arbiter drives one registered write per cycle onto the shared port and honours downstream backpressure.
- Sits between bus masters (CPU-side, DMA, debug) and the write-port consumer.

Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i is at [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed data, same packing.
- req_ready  out  N_REQ  one-hot accept; combinational from valid, pointer and bus state.
- bus_ready  in  1  consumer can take the current write.
- addr  out  ADDR_W  registered write address.
- data  out  DATA_W  registered write data.
- wen  out  1  registered write enable.
- grant_id  out  $clog2(N_REQ)  requester that owns the current addr/data/wen.
- Interface rule (already decided): one clock, clk; reset rst_n is asynchronous, active-low.

Behaviour:
- Reset (async assert, sync release):
  - addr, data, wen and grant_id all 0.
  - Round-robin pointer ptr = 0; lock cleared.
  - An in-flight write is dropped. Requesters must re-present after reset.
- Winner selection: g = first i with req_valid[i], searching from ptr upward with wrap modulo N_REQ. No valid request means no winner.
- Slot free: slot_free = ~wen | bus_ready.
- req_ready[g] = slot_free when a winner exists. All other req_ready bits are 0, and all are 0 with no winner.
- Accept = req_valid[g] & req_ready[g]. On the next edge:
  - addr/data load from requester g.
  - wen = 1, grant_id = g.
  - ptr = (g+1) mod N_REQ.
- Latency: accept in cycle t produces wen=1 at cycle t+1. Sustained throughput is 1 write per cycle while bus_ready=1.
- No accept and bus_ready=1: wen clears to 0. addr, data and grant_id hold their last values.
- wen=1 and bus_ready=0 (stall): addr, data, wen and grant_id all hold. No req_ready is asserted. ptr holds.
- ptr changes only on accept. A requester that drops valid before being accepted loses nothing, and no fairness credit is kept.
- All N_REQ valid continuously with bus_ready=1: grants in order 0,1,…,N_REQ-1,0,…
- Single requester valid continuously: granted every cycle, back-to-back.
- req_valid must stay high with stable addr/data until accepted. The arbiter does not check this.

Optional Feature:
- Macro: WR_BUS_ARBITER_LOCK_EN.
- Defined:
  - Adds input port req_lock [N_REQ].
  - On accept of g with req_lock[g]=1, the lock is set with owner g.
  - While locked, only the owner can win. Other requesters see req_ready=0 even when the owner is not valid.
  - The lock clears on an accept from the owner with req_lock[owner]=0 (last beat of the burst).
  - ptr advances only when the lock clears.
  - Reset clears the lock.
- Undefined: no req_lock port; pure round-robin as above.

Decomposition:
- Package wr_bus_pkg: ADDR_W/DATA_W defaults and a wr_req_t struct {addr, data}.
- Sub-module rr_pick (N_REQ param): takes valid vector and ptr, produces one-hot grant and index. It is purely combinational and reused by other arbiters.
- Top block holds the pointer, lock and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-stall with wen=1 -> wen, addr, data, grant_id = 0 immediately (asynchronous); after release the first grant goes to the lowest valid index from ptr=0.
- Single write: req 0 valid, addr=8'hca, data=8'hfe, bus_ready=1 -> req_ready[0] same cycle; next cycle wen=1, addr=8'hca, data=8'hfe, grant_id=0; following cycle wen=0.
- Fairness: all 4 valid for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 with wen=1 on every cycle.
- Backpressure: hold bus_ready=0 for 3 cycles while wen=1 with addr=8'hb0, data=8'hba -> outputs stable, req_ready=0, ptr unchanged; release -> next grant follows the stalled owner.
- Wrap and skip: ptr=3, only req 1 valid with addr=8'hde, data=8'had -> grant_id=1, then ptr=2.
- LOCK_EN: requester 2 locks 3 beats while requester 0 is valid -> grant_id 2,2,2, then 0; requester 0 gets req_ready=0 throughout the burst.

Source files
------------

// File: rtl/wr_bus_pkg.sv
// Shared defaults and request payload type for the write-port arbiter family.
package wr_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

  logic [N_REQ-1:0][PTR_W-1:0] cand_idx;
  logic [N_REQ-1:0]            rot_valid;

  // Position gi of the rotated view holds requester (ptr + gi) mod N_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      assign sum            = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign cand_idx[gi]   = (sum >= N_EXT) ? PTR_W'(sum - N_EXT) : sum[PTR_W-1:0];
      assign rot_valid[gi]  = valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    idx   = '0;
    found = 1'b0;
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        idx   = cand_idx[k];
        found = 1'b1;
      end
    end
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/wr_bus_arbiter.sv
// Round-robin arbiter sharing one registered write port between N_REQ requesters.
// Define WR_BUS_ARBITER_LOCK_EN to add req_lock burst locking.
module wr_bus_arbiter
  import wr_bus_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int PTR_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef WR_BUS_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]        req_lock,
`endif
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    bus_ready,
  output logic [ADDR_W-1:0]       addr,
  output logic [DATA_W-1:0]       data,
  output logic                    wen,
  output logic [PTR_W-1:0]        grant_id
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_REQ);

  logic [N_REQ-1:0][ADDR_W-1:0] addr_arr;
  logic [N_REQ-1:0][DATA_W-1:0] data_arr;
  assign addr_arr = req_addr;
  assign data_arr = req_data;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wen_q, wen_d;
  logic [PTR_W-1:0]  gid_q, gid_d;

  logic [N_REQ-1:0]  cand_valid;
  logic [N_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_found;
  logic              slot_free;
  logic              accept;
  logic [PTR_W:0]    ptr_inc_ext;
  logic [PTR_W-1:0]  ptr_after;

`ifdef WR_BUS_ARBITER_LOCK_EN
  logic             lock_q, lock_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] owner_mask;

  // While locked only the owner may compete, even if it is momentarily idle.
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    cand_valid          = lock_q ? (req_valid & owner_mask) : req_valid;
  end
`else
  assign cand_valid = req_valid;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid (cand_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign slot_free   = ~wen_q | bus_ready;
  assign accept      = pick_found & slot_free;
  assign req_ready   = accept ? pick_grant : '0;
  assign ptr_inc_ext = {1'b0, pick_idx} + (PTR_W+1)'(1);
  assign ptr_after   = (ptr_inc_ext == N_EXT) ? '0 : ptr_inc_ext[PTR_W-1:0];

  always_comb begin
    ptr_d  = ptr_q;
    addr_d = addr_q;
    data_d = data_q;
    wen_d  = wen_q;
    gid_d  = gid_q;
`ifdef WR_BUS_ARBITER_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
`endif
    if (accept) begin
      addr_d = addr_arr[pick_idx];
      data_d = data_arr[pick_idx];
      wen_d  = 1'b1;
      gid_d  = pick_idx;
`ifdef WR_BUS_ARBITER_LOCK_EN
      // Pointer only moves on the unlocked (final) beat of a burst.
      if (req_lock[pick_idx]) begin
        lock_d  = 1'b1;
        owner_d = pick_idx;
      end else begin
        lock_d = 1'b0;
        ptr_d  = ptr_after;
      end
`else
      ptr_d = ptr_after;
`endif
    end else if (bus_ready) begin
      wen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
      gid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wen_q  <= wen_d;
      gid_q  <= gid_d;
    end
  end

`ifdef WR_BUS_ARBITER_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`endif

  assign addr     = addr_q;
  assign data     = data_q;
  assign wen      = wen_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_wr_bus_arbiter.sv
// Bench for wr_bus_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wr_bus_arbiter;
  import wr_bus_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_addr;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           bus_ready;
  logic [7:0]     addr;
  logic [7:0]     data;
  logic           wen;
  logic [1:0]     grant_id;
`ifdef WR_BUS_ARBITER_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wr_bus_arbiter #(.N_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef WR_BUS_ARBITER_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .bus_ready (bus_ready),
    .addr      (addr),
    .data      (data),
    .wen       (wen),
    .grant_id  (grant_id)
  );

  // Reference model state, in plain integers
  int      m_ptr;
  bit      m_lock;
  int      m_owner;
  wr_req_t m_out;
  bit      m_wen;
  int      m_gid;

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i] && (!m_lock || i == m_owner)) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = model_winner();
    if (w >= 0 && (!m_wen || bus_ready)) r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_owner = 0; m_out = '0; m_wen = 0; m_gid = 0;
  endtask

  // Advance model by one clock using current inputs, then step the DUT to the next falling edge.
  task automatic tick();
    int w;
    w = model_winner();
    if (w >= 0 && (!m_wen || bus_ready)) begin
      m_out.addr = req_addr[w*8 +: 8];
      m_out.data = req_data[w*8 +: 8];
      m_wen = 1;
      m_gid = w;
`ifdef WR_BUS_ARBITER_LOCK_EN
      if (req_lock[w]) begin
        m_lock = 1; m_owner = w;
      end else begin
        m_lock = 0; m_ptr = (w + 1) % N;
      end
`else
      m_ptr = (w + 1) % N;
`endif
      $display("txn t=%0t req=%0d addr=%h data=%h", $time, w, m_out.addr, m_out.data);
    end else if (bus_ready) begin
      m_wen = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_data = '0; bus_ready = 1'b1;
`ifdef WR_BUS_ARBITER_LOCK_EN
    req_lock = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*8 +: 8] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    @(negedge clk);
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", wen); end
    total++; if (addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    rst_n = 1'b1;
    set_req(1, 8'h31, 8'h41);
    set_req(2, 8'h32, 8'h42);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL reset_first_ready got=%b exp=0010", req_ready); end
    tick();
    total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL reset_first_gid got=%0d exp=1", grant_id); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 8'h11, 8'h22);
    tick();
    req_valid = '0;
    bus_ready = 1'b0;
    tick();
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL stall_before_reset_wen got=%b exp=1", wen); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({wen, addr, data, grant_id} !== 19'd0)
      begin bad++; $display("FAIL async_reset got wen=%b addr=%h data=%h gid=%0d exp all 0", wen, addr, data, grant_id); end
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 8'h50, 8'h51);
    set_req(3, 8'h53, 8'h54);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL post_reset_ready got=%b exp=0001", req_ready); end
    tick();
    total++; if (grant_id !== 2'd0 || addr !== 8'h50) begin bad++; $display("FAIL post_reset_grant got gid=%0d addr=%h exp gid=0 addr=50", grant_id, addr); end
  endtask

  task automatic test_single_write();
    do_reset();
    set_req(0, 8'hca, 8'hfe);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL single_wen got=%b exp=1", wen); end
    total++; if (addr !== 8'hca) begin bad++; $display("FAIL single_addr got=%h exp=ca", addr); end
    total++; if (data !== 8'hfe) begin bad++; $display("FAIL single_data got=%h exp=fe", data); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_gid got=%0d exp=0", grant_id); end
    tick();
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL single_idle_wen got=%b exp=0", wen); end
    total++; if (addr !== 8'hca) begin bad++; $display("FAIL single_hold_addr got=%h exp=ca", addr); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_r;
    logic [1:0]   exp_g;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h60 + i), 8'(8'h70 + i));
    for (int k = 0; k < 8; k++) begin
      exp_r = 4'b0001 << (k % N);
      exp_g = 2'(k % N);
      #1;
      total++; if (req_ready !== exp_r) begin bad++; $display("FAIL fair_ready[%0d] got=%b exp=%b", k, req_ready, exp_r); end
      tick();
      total++; if (grant_id !== exp_g || wen !== 1'b1)
        begin bad++; $display("FAIL fair_grant[%0d] got gid=%0d wen=%b exp gid=%0d wen=1", k, grant_id, wen, exp_g); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(2, 8'hb0, 8'hba);
    tick();
    req_valid = '0;
    set_req(0, 8'h01, 8'h02);
    set_req(1, 8'h03, 8'h04);
    set_req(3, 8'h05, 8'h06);
    bus_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0000", k, req_ready); end
      tick();
      total++; if ({wen, grant_id, addr, data} !== {1'b1, 2'd2, 8'hb0, 8'hba})
        begin bad++; $display("FAIL stall_hold[%0d] got wen=%b gid=%0d addr=%h data=%h exp 1/2/b0/ba", k, wen, grant_id, addr, data); end
    end
    bus_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_release_ready got=%b exp=1000", req_ready); end
    tick();
    total++; if (grant_id !== 2'd3 || addr !== 8'h05) begin bad++; $display("FAIL stall_release_gid got=%0d addr=%h exp 3/05", grant_id, addr); end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    set_req(2, 8'h22, 8'h33);
    tick();
    req_valid = '0;
    set_req(1, 8'hde, 8'had);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wrap_ready got=%b exp=0010", req_ready); end
    tick();
    total++; if ({grant_id, addr, data} !== {2'd1, 8'hde, 8'had})
      begin bad++; $display("FAIL wrap_grant got gid=%0d addr=%h data=%h exp 1/de/ad", grant_id, addr, data); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_ptr_ready got=%b exp=0100", req_ready); end
    tick();
  endtask

`ifdef WR_BUS_ARBITER_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_req(1, 8'h11, 8'h11);
    tick();
    req_valid = '0;
    set_req(0, 8'h10, 8'h90);
    set_req(2, 8'h20, 8'ha0);
    for (int b = 0; b < 3; b++) begin
      req_lock[2] = (b < 2);
      req_addr[2*8 +: 8] = 8'(8'h20 + b);
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL lock_ready[%0d] got=%b exp=0100", b, req_ready); end
      tick();
      total++; if (grant_id !== 2'd2 || addr !== 8'(8'h20 + b))
        begin bad++; $display("FAIL lock_beat[%0d] got gid=%0d addr=%h exp 2/%h", b, grant_id, addr, 8'(8'h20 + b)); end
      if (b == 0) begin
        req_valid[2] = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL lock_gap_ready got=%b exp=0000", req_ready); end
        tick();
        req_valid[2] = 1'b1;
      end
    end
    req_lock = '0;
    req_valid[2] = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL lock_after_ready got=%b exp=0001", req_ready); end
    tick();
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL lock_after_gid got=%0d exp=0", grant_id); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      req_addr  = $urandom();
      req_data  = $urandom();
      bus_ready = ($urandom_range(0, 3) != 0);
`ifdef WR_BUS_ARBITER_LOCK_EN
      for (int i = 0; i < N; i++) req_lock[i] = ($urandom_range(0, 3) == 0);
`endif
      exp_r = model_ready();
      #1;
      total++; if (req_ready !== exp_r) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, req_ready, exp_r); end
      tick();
      total++; if ({wen, grant_id, addr, data} !== {m_wen, 2'(m_gid), m_out.addr, m_out.data})
        begin bad++; $display("FAIL rand_out[%0d] got wen=%b gid=%0d addr=%h data=%h exp wen=%b gid=%0d addr=%h data=%h",
          c, wen, grant_id, addr, data, m_wen, m_gid, m_out.addr, m_out.data); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_backpressure();
    test_wrap_skip();
    test_async_reset();
`ifdef WR_BUS_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
